// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/shift ops, plus iterative mult/multu/div/divu
// that share the HI/LO registers with mfhi/mflo/mthi/mtlo.
//
// Handshake: an input op transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Once
// out_valid is high, dataOut/status hold until that transfer. Both transfers
// may happen on the same edge.
module alu_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = 5,
  parameter int STATUS_WIDTH = 4,
  parameter int SHAMT_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   dataIn,
  input  logic [CTRL_WIDTH-1:0]     ctrl,
  input  logic [SHAMT_WIDTH-1:0]    shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     dataOut,
  output logic [STATUS_WIDTH-1:0]   status,
  output logic                      busy
);

  localparam int W = DATA_WIDTH;

  localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(8'h00);
  localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(8'h01);
  localparam logic [CTRL_WIDTH-1:0] OP_NOR   = CTRL_WIDTH'(8'h02);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(8'h03);
  localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(8'h04);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(8'h05);
  localparam logic [CTRL_WIDTH-1:0] OP_MULT  = CTRL_WIDTH'(8'h06);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(8'h07);
  localparam logic [CTRL_WIDTH-1:0] OP_SRLI  = CTRL_WIDTH'(8'h08);
  localparam logic [CTRL_WIDTH-1:0] OP_SLLI  = CTRL_WIDTH'(8'h09);
  localparam logic [CTRL_WIDTH-1:0] OP_SRAI  = CTRL_WIDTH'(8'h0a);
  localparam logic [CTRL_WIDTH-1:0] OP_MFHI  = CTRL_WIDTH'(8'h0b);
  localparam logic [CTRL_WIDTH-1:0] OP_MFLO  = CTRL_WIDTH'(8'h0c);
  localparam logic [CTRL_WIDTH-1:0] OP_MTHI  = CTRL_WIDTH'(8'h0d);
  localparam logic [CTRL_WIDTH-1:0] OP_MTLO  = CTRL_WIDTH'(8'h0e);
  localparam logic [CTRL_WIDTH-1:0] OP_SRLV  = CTRL_WIDTH'(8'h0f);
  localparam logic [CTRL_WIDTH-1:0] OP_SLLV  = CTRL_WIDTH'(8'h10);
  localparam logic [CTRL_WIDTH-1:0] OP_SRAV  = CTRL_WIDTH'(8'h11);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU  = CTRL_WIDTH'(8'h12);
  localparam logic [CTRL_WIDTH-1:0] OP_MULTU = CTRL_WIDTH'(8'h13);
  localparam logic [CTRL_WIDTH-1:0] OP_DIV   = CTRL_WIDTH'(8'h14);
  localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(8'h15);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]           dout_q, dout_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d;
  logic                   out_valid_q, out_valid_d;
  // acc holds {upper, lower}: product halves for multiply,
  // {remainder, quotient-in-progress} for divide.
  logic [2*W-1:0]         acc_q, acc_d;
  logic [W-1:0]           a_q, a_d;        // original dividend, for divide-by-zero HI
  logic [W-1:0]           bmag_q, bmag_d;  // multiplicand / divisor magnitude
  logic                   sa_q, sa_d, sb_q, sb_d, is_div_q, is_div_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;

  logic [W-1:0] a_in, b_in, amag_in, bmag_in;
  logic         accept, op_signed, op_div, op_iter, sa_in, sb_in;

  assign a_in      = dataIn[2*W-1:W];
  assign b_in      = dataIn[W-1:0];
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign op_signed = (ctrl == OP_MULT) || (ctrl == OP_DIV);
  assign op_div    = (ctrl == OP_DIV) || (ctrl == OP_DIVU);
  assign op_iter   = op_div || (ctrl == OP_MULT) || (ctrl == OP_MULTU);
  assign sa_in     = op_signed && a_in[W-1];
  assign sb_in     = op_signed && b_in[W-1];
  assign amag_in   = sa_in ? -a_in : a_in;
  assign bmag_in   = sb_in ? -b_in : b_in;

  // Single-cycle operation result and arithmetic flags.
  logic [W-1:0] alu_res;
  logic         alu_carry, alu_ovf;
  logic [W:0]   add_full, sub_full;
  assign add_full = {1'b0, a_in} + {1'b0, b_in};
  assign sub_full = {1'b0, a_in} - {1'b0, b_in};

  // Decode of the single-cycle opcodes.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (ctrl)
      OP_AND:  alu_res = a_in & b_in;
      OP_OR:   alu_res = a_in | b_in;
      OP_NOR:  alu_res = ~(a_in | b_in);
      OP_XOR:  alu_res = a_in ^ b_in;
      OP_ADD: begin
        alu_res   = add_full[W-1:0];
        alu_carry = add_full[W];
        alu_ovf   = (a_in[W-1] == b_in[W-1]) && (add_full[W-1] != a_in[W-1]);
      end
      OP_SUB: begin
        alu_res   = sub_full[W-1:0];
        alu_carry = sub_full[W];
        alu_ovf   = (a_in[W-1] != b_in[W-1]) && (sub_full[W-1] != a_in[W-1]);
      end
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (a_in < b_in)};
      OP_SRLI: alu_res = b_in >> shamt;
      OP_SLLI: alu_res = b_in << shamt;
      OP_SRAI: alu_res = $signed(b_in) >>> shamt;
      OP_SRLV: alu_res = a_in >> b_in[SHAMT_WIDTH-1:0];
      OP_SLLV: alu_res = a_in << b_in[SHAMT_WIDTH-1:0];
      OP_SRAV: alu_res = $signed(a_in) >>> b_in[SHAMT_WIDTH-1:0];
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI, OP_MTLO: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // One iteration step for each algorithm, plus final sign fix-up.
  logic [W:0]     mul_sum, div_shift;
  logic [W-1:0]   div_rem;
  logic           div_ge;
  logic [2*W-1:0] mul_next, div_next, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;
  logic           fin_ovf, min_neg1;

  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
  assign mul_next  = {mul_sum, acc_q[W-1:1]};
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, bmag_q};
  assign div_rem   = div_ge ? W'(div_shift - {1'b0, bmag_q}) : div_shift[W-1:0];
  assign div_next  = {div_rem, acc_q[W-2:0], div_ge};
  assign prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix   = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix   = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  // MIN / -1 already yields LO=MIN, HI=0 from the magnitude path; only flag it.
  assign min_neg1  = sa_q && sb_q && (a_q == {1'b1, {(W-1){1'b0}}}) && (bmag_q == W'(1));

  // Final HI/LO selection including the divide exceptions.
  always_comb begin
    fin_hi  = prod_fix[2*W-1:W];
    fin_lo  = prod_fix[W-1:0];
    fin_ovf = 1'b0;
    if (is_div_q) begin
      if (bmag_q == '0) begin
        fin_lo  = '1;
        fin_hi  = a_q;
        fin_ovf = 1'b1;
      end else begin
        fin_lo  = quo_fix;
        fin_hi  = rem_fix;
        fin_ovf = min_neg1;
      end
    end
  end

  // Next-state and datapath updates for IDLE / ITER / DONE.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dout_d      = dout_q;
    status_d    = status_q;
    out_valid_d = out_valid_q && !out_ready;
    acc_d       = acc_q;
    a_d         = a_q;
    bmag_d      = bmag_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_iter) begin
            state_d  = S_ITER;
            cnt_d    = '0;
            a_d      = a_in;
            bmag_d   = bmag_in;
            sa_d     = sa_in;
            sb_d     = sb_in;
            is_div_d = op_div;
            acc_d    = {{W{1'b0}}, amag_in};
          end else begin
            dout_d      = alu_res;
            status_d    = {alu_ovf, alu_carry, alu_res[W-1], (alu_res == '0)};
            out_valid_d = 1'b1;
            if (ctrl == OP_MTHI) hi_d = b_in;
            if (ctrl == OP_MTLO) lo_d = b_in;
          end
        end
      end
      S_ITER: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHAMT_WIDTH'(W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q || out_ready) begin
          hi_d        = fin_hi;
          lo_d        = fin_lo;
          dout_d      = fin_lo;
          status_d    = {fin_ovf, 1'b0, fin_lo[W-1], (fin_lo == '0)};
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and result registers; reset discards any iteration in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      dout_q      <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      a_q         <= '0;
      bmag_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dout_q      <= dout_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      bmag_q      <= bmag_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dataOut   = dout_q;
  assign status    = status_q;
  assign busy      = (state_q == S_ITER);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Second-generation ALU for the datapath: width-parametrised, with valid/ready handshakes on input and output.
- Adds iterative signed and unsigned multiply and divide that share HI/LO registers.
- Produces correct signed-overflow, carry and divide-exception flags.
- Sits between the register-read stage and writeback. The issue stage stalls on in_ready; writeback consumes results via out_ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and ≥8.
- CTRL_WIDTH, 5, opcode width.
- STATUS_WIDTH, 4, status bits, fixed at 4: {ovf, carry, sign, zero}.
- SHAMT_WIDTH, 5, shift-amount width; must equal clog2(DATA_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- dataIn  in  2*DATA_WIDTH  {A, B}: A = bits [2W-1:W], B = bits [W-1:0]
- ctrl  in  CTRL_WIDTH  opcode
- shamt  in  SHAMT_WIDTH  immediate shift amount
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- dataOut  out  DATA_WIDTH  result
- status  out  STATUS_WIDTH  [0] zero, [1] sign, [2] carry, [3] overflow
- busy  out  1  multiply/divide iterating

Behaviour:
- Reset (async): out_valid=0, dataOut=0, status=0, busy=0, HI=LO=0, FSM=IDLE. Reset during an iteration aborts it with no result.
- FSM states: IDLE, ITER, DONE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An accept and an output pop may occur in the same cycle.
- Every accepted op produces exactly one result.
- Single-cycle ops: result registered on the accept edge; out_valid rises the next cycle (latency 1).
- Opcodes, with W = DATA_WIDTH:
  - 0x00 and, 0x01 or, 0x02 nor, 0x03 xor (A op B).
  - 0x04 add: A+B, carry = bit W of the (W+1)-bit sum.
  - 0x05 sub: A-B, carry = borrow (1 when A<B unsigned).
  - add/sub overflow = signed overflow, i.e. operand signs equal (add) or differ (sub) and the result sign differs from A.
  - 0x07 slt signed, 0x12 sltu: result 1 or 0.
  - 0x08 srl B>>shamt, 0x09 sll B<<shamt, 0x0a sra B>>>shamt.
  - 0x0f srl, 0x10 sll, 0x11 sra: A shifted by B[SHAMT_WIDTH-1:0]. Upper bits of B are ignored.
  - 0x0b mfhi, 0x0c mflo: result = HI or LO.
  - 0x0d mthi, 0x0e mtlo: HI or LO = B; result = 0, status = 0001.
  - 0x06 mult signed, 0x13 multu, 0x14 div signed, 0x15 divu: iterative, see below.
  - Any other opcode: result 0, status 0001 (zero set).
- Flags for all non-arithmetic ops: zero = (result==0), sign = result[W-1], carry=0, ovf=0.
- Multiply/divide:
  - Accept moves FSM IDLE→ITER. busy=1 for exactly W cycles of ITER, one bit per cycle.
  - Multiply is shift-add on magnitudes; divide is restoring on magnitudes. Signs are fixed up in DONE.
  - DONE lasts one cycle: writes HI/LO, registers the result, sets out_valid, then returns to IDLE.
  - Latency from accept edge to out_valid = W+2 cycles.
  - mult/multu: {HI,LO} = 2W-bit product; dataOut = LO.
  - div/divu: LO = quotient (truncated toward zero), HI = remainder (sign of dividend); dataOut = LO.
  - Multiply/divide flags: zero/sign from dataOut, carry=0.
  - Divide by zero (B==0): LO = all ones, HI = A, ovf=1. Takes the normal latency; no early exit.
  - Signed div of MIN by -1: LO = MIN, HI = 0, ovf=1.
  - mfhi/mflo cannot observe a partial HI/LO, because in_ready=0 while busy.
- Backpressure:
  - out_valid stays high, with dataOut and status stable, until out_ready.
  - While out_valid && !out_ready, in_ready=0.
  - If out_valid is still held at the end of ITER, the FSM stays in DONE until out_ready.
- ctrl/dataIn/shamt are sampled only on accept; changes at other times are ignored.

Test Plan:
- add 0x7FFFFFFF+1 → dataOut 0x80000000, status 1010 (ovf, sign). Then sub 0-1 → 0xFFFFFFFF, status 0110 (carry/borrow, sign).
- mult A=-3, B=5 → out_valid exactly 34 cycles after accept; LO=0xFFFFFFF1, HI=0xFFFFFFFF. Then mfhi → 0xFFFFFFFF.
- div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → LO=0xFFFFFFFF, HI=7, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after an add → dataOut stable, in_ready=0. Release out_ready with a new op valid → pop and accept in the same cycle.
- Back-to-back: xor, sra (B=0x80000000, shamt=4 → 0xF8000000), slt(-1,1)=1, sltu(-1,1)=0 → one result per cycle with out_ready=1.
- Assert rst at cycle 10 of a div → out_valid=0, busy=0, HI=LO=0 immediately. A following and op completes normally.
